scoreboard_ctrl: RTL and testbench

SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

---
 rtl/scoreboard_ctrl.sv | 111 +++++++++++
 tb/tb_scoreboard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// Register scoreboard: tracks a pending write per architectural register and blocks issue on RAW/WAW hazards.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release a hazard immediately.
module scoreboard_ctrl #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_issue_valid,
    input  logic [4:0]             i_rs1_addr,
    input  logic [4:0]             i_rs2_addr,
    input  logic                   i_rs1_used,
    input  logic                   i_rs2_used,
    input  logic [4:0]             i_rd_addr,
    input  logic                   i_rd_wen,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_addr,
    output logic                   o_issue_ready,
    output logic                   o_stall,
    output logic [31:0]            o_pending,
    output logic [5:0]             o_outstanding,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {
        REG_IDLE    = 1'b0,
        REG_PENDING = 1'b1
    } reg_state_e;

    // x0 has no entry: it can never be pending.
    reg_state_e             r_state      [1:31];
    reg_state_e             w_state_next [1:31];
    logic [5:0]             r_outstanding;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_pending;
    logic [31:0] w_hazard_view;
    logic [31:0] w_set_vec;
    logic [31:0] w_clr_vec;
    logic        w_clr;
    logic        w_set;
    logic        w_same;
    logic        w_raw;
    logic        w_waw;

    always_comb begin
        w_pending = '0;
        for (int i = 1; i < 32; i++) begin
            w_pending[i] = (r_state[i] == REG_PENDING);
        end
    end

    assign w_clr     = i_wb_valid && (i_wb_addr != 5'd0) && w_pending[i_wb_addr];
    assign w_clr_vec = w_clr ? (32'd1 << i_wb_addr) : 32'd0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_hazard_view = w_pending & ~w_clr_vec;
`else
    assign w_hazard_view = w_pending;
`endif

    assign w_raw         = (i_rs1_used && w_hazard_view[i_rs1_addr]) ||
                           (i_rs2_used && w_hazard_view[i_rs2_addr]);
    assign w_waw         = i_rd_wen && w_hazard_view[i_rd_addr];
    assign o_issue_ready = !(w_raw || w_waw);
    assign o_stall       = i_issue_valid && !o_issue_ready;

    assign w_set     = i_issue_valid && o_issue_ready && i_rd_wen && (i_rd_addr != 5'd0);
    assign w_set_vec = w_set ? (32'd1 << i_rd_addr) : 32'd0;
    // Only possible with bypass: the same register retires and is re-claimed; set wins.
    assign w_same    = |(w_set_vec & w_clr_vec);

    // NOTE: defaults are assigned before the case so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                REG_IDLE:    if (w_set_vec[i])                  w_state_next[i] = REG_PENDING;
                REG_PENDING: if (w_clr_vec[i] && !w_set_vec[i]) w_state_next[i] = REG_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values; the state array is
    // ordinary flops, so it is cleared by the async reset like the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                r_state[i] <= REG_IDLE;
            end
            r_outstanding <= '0;
            r_stall_cnt   <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                r_state[i] <= w_state_next[i];
            end
            case ({w_set && !w_same, w_clr && !w_same})
                2'b10:   r_outstanding <= r_outstanding + 6'd1;
                2'b01:   r_outstanding <= r_outstanding - 6'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (o_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign o_pending     = w_pending;
    assign o_outstanding = r_outstanding;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Self-checking bench for scoreboard_ctrl: per-cycle expectations from a set-based model are queued
// by the driver and popped by a negedge monitor; honours SCOREBOARD_WB_BYPASS_EN when defined.
module tb_scoreboard_ctrl;

    localparam int unsigned SCW = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           i_issue_valid;
    logic [4:0]     i_rs1_addr;
    logic [4:0]     i_rs2_addr;
    logic           i_rs1_used;
    logic           i_rs2_used;
    logic [4:0]     i_rd_addr;
    logic           i_rd_wen;
    logic           i_wb_valid;
    logic [4:0]     i_wb_addr;
    logic           o_issue_ready;
    logic           o_stall;
    logic [31:0]    o_pending;
    logic [5:0]     o_outstanding;
    logic [SCW-1:0] o_stall_cnt;

    scoreboard_ctrl #(.STALL_CNT_W(SCW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_issue_valid(i_issue_valid),
        .i_rs1_addr   (i_rs1_addr),
        .i_rs2_addr   (i_rs2_addr),
        .i_rs1_used   (i_rs1_used),
        .i_rs2_used   (i_rs2_used),
        .i_rd_addr    (i_rd_addr),
        .i_rd_wen     (i_rd_wen),
        .i_wb_valid   (i_wb_valid),
        .i_wb_addr    (i_wb_addr),
        .o_issue_ready(o_issue_ready),
        .o_stall      (o_stall),
        .o_pending    (o_pending),
        .o_outstanding(o_outstanding),
        .o_stall_cnt  (o_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_used;
        logic [4:0] rs2;
        logic       rs2_used;
        logic [4:0] rd;
        logic       rd_wen;
        logic       wb_valid;
        logic [4:0] wb_addr;
    } stim_t;

    typedef struct packed {
        logic           ready;
        logic           stall;
        logic [31:0]    pending;
        logic [5:0]     outstanding;
        logic [SCW-1:0] stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   m_pend [32];
    int   m_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                                 input int rd, input bit w, input bit wbv, input int wba);
        stim_t s;
        s.valid    = v;
        s.rs1      = 5'(rs1);
        s.rs1_used = u1;
        s.rs2      = 5'(rs2);
        s.rs2_used = u2;
        s.rd       = 5'(rd);
        s.rd_wen   = w;
        s.wb_valid = wbv;
        s.wb_addr  = 5'(wba);
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Reference: a register blocks issue if it is in the pending set (minus a same-cycle
    // writeback when bypass is built in); x0 is never in the set.
    function automatic bit model_ready(input stim_t s);
        bit busy [32];
        busy = m_pend;
        if (BYPASS && s.wb_valid) busy[s.wb_addr] = 1'b0;
        busy[0] = 1'b0;
        return !((s.rs1_used && busy[s.rs1]) || (s.rs2_used && busy[s.rs2]) || (s.rd_wen && busy[s.rd]));
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic apply(input stim_t s);
        i_issue_valid = s.valid;
        i_rs1_addr    = s.rs1;
        i_rs1_used    = s.rs1_used;
        i_rs2_addr    = s.rs2;
        i_rs2_used    = s.rs2_used;
        i_rd_addr     = s.rd;
        i_rd_wen      = s.rd_wen;
        i_wb_valid    = s.wb_valid;
        i_wb_addr     = s.wb_addr;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   rdy;
        @(posedge clk);
        #1;
        apply(s);
        rdy           = model_ready(s);
        e.ready       = rdy;
        e.stall       = s.valid && !rdy;
        e.pending     = model_vec();
        e.outstanding = 6'(model_count());
        e.stall_cnt   = SCW'(m_cnt);
        exp_q.push_back(e);
        if (s.wb_valid && s.wb_addr != 5'd0) m_pend[s.wb_addr] = 1'b0;
        if (s.valid && rdy && s.rd_wen && s.rd != 5'd0) m_pend[s.rd] = 1'b1;
        if (s.valid && !rdy && m_cnt < (2 ** SCW) - 1) m_cnt++;
    endtask

    // Async reset asserted mid-cycle with a hazardous issue presented; released between edges.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        apply(mk(1, 3, 1, 4, 1, 3, 1, 1, 3));
        #1;
        check("rst_pending", o_pending, 32'h0);
        check("rst_outstanding", 32'(o_outstanding), 32'h0);
        check("rst_stall_cnt", 32'(o_stall_cnt), 32'h0);
        check("rst_ready", 32'(o_issue_ready), 32'h1);
        check("rst_stall", 32'(o_stall), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_pending", o_pending, 32'h0);
        check("rst_hold_outstanding", 32'(o_outstanding), 32'h0);
        apply(idle());
        #2;
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("issue_ready", 32'(o_issue_ready), 32'(mon_e.ready));
                check("stall", 32'(o_stall), 32'(mon_e.stall));
                check("pending", o_pending, mon_e.pending);
                check("outstanding", 32'(o_outstanding), 32'(mon_e.outstanding));
                check("stall_cnt", 32'(o_stall_cnt), 32'(mon_e.stall_cnt));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        apply(idle());
        model_clear();
        #2;
        rst = 1'b0;
        #1;
        check("init_pending", o_pending, 32'h0);
        check("init_outstanding", 32'(o_outstanding), 32'h0);
        check("init_ready", 32'(o_issue_ready), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;

        // RAW on x5 held until writeback
        step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0));
        repeat (3) step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0));
        step(mk(1, 5, 1, 0, 0, 0, 0, 1, 5));
        step(mk(1, 5, 1, 0, 0, 0, 0, 0, 0));
        step(idle());

        // x0 is never pending and never blocks
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        step(mk(1, 0, 1, 0, 1, 0, 1, 0, 0));
        step(idle());

        // set/clear collision on x7
        step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0));
        step(idle());
        step(mk(1, 0, 0, 0, 0, 7, 1, 1, 7));
        step(idle());
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 7));
        step(idle());

        // mid-run reset with only x2 pending
        do_reset();
        step(mk(1, 0, 0, 0, 0, 2, 1, 0, 0));
        repeat (3) step(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre_rst_pending", o_pending, 32'h4);
        do_reset();

        // stall counter saturation
        step(mk(1, 0, 0, 0, 0, 3, 1, 0, 0));
        repeat (20) step(mk(1, 3, 1, 0, 0, 0, 0, 0, 0));
        #2;
        check("sat_cnt", 32'(o_stall_cnt), 32'd15);
        step(mk(1, 0, 0, 3, 1, 0, 0, 0, 0));
        step(idle());
        #2;
        check("sat_hold", 32'(o_stall_cnt), 32'd15);

        // fill all 31 registers, then spurious writebacks
        do_reset();
        for (int r = 1; r < 32; r++) step(mk(1, 0, 0, 0, 0, r, 1, 0, 0));
        step(idle());
        #2;
        check("fill_outstanding", 32'(o_outstanding), 32'd31);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9));
        step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0));
        step(idle());
        #2;
        check("refill_outstanding", 32'(o_outstanding), 32'd31);

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            s.valid    = ($urandom_range(0, 3) != 0);
            s.rs1      = 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
            s.rs2      = 5'($urandom_range(0, 7));
            s.rs1_used = 1'($urandom_range(0, 1));
            s.rs2_used = 1'($urandom_range(0, 1));
            s.rd       = 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
            s.rd_wen   = ($urandom_range(0, 3) != 0);
            s.wb_valid = ($urandom_range(0, 9) < 4);
            s.wb_addr  = 5'($urandom_range(0, 7));
            step(s);
        end

        step(idle());
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
